// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic-light monitor: phases, light patterns,
// error codes and the 7-segment glyph table.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      PH_SYNC        = 3'd0,
      PH_RED         = 3'd1,
      PH_RED_YELLOW  = 3'd2,
      PH_GREEN       = 3'd3,
      PH_GREEN_BLINK = 3'd4,
      PH_YELLOW      = 3'd5
   } phase_e;

   // lights_in is {green, yellow, red}
   typedef enum logic [2:0] {
      PAT_OFF = 3'b000,
      PAT_R   = 3'b001,
      PAT_Y   = 3'b010,
      PAT_RY  = 3'b011,
      PAT_G   = 3'b100
   } pat_e;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_ILLEGAL      = 3'd1,
      ERR_EARLY        = 3'd2,
      ERR_LATE         = 3'd3,
      ERR_WRONG_NEXT   = 3'd4,
      ERR_SEG_MISMATCH = 3'd5,
      ERR_SEG_INVALID  = 3'd6
   } err_e;

   // Segments ordered g..a, active-high
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b0111111;
         4'd1:    g = 7'b0000110;
         4'd2:    g = 7'b1011011;
         4'd3:    g = 7'b1001111;
         4'd4:    g = 7'b1100110;
         4'd5:    g = 7'b1101101;
         4'd6:    g = 7'b1111101;
         4'd7:    g = 7'b0000111;
         4'd8:    g = 7'b1111111;
         4'd9:    g = 7'b1101111;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment to BCD decode; non-glyph patterns give digit 0
// with valid low.
module seg7_decoder
   import traffic_light_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       valid
);

   always_comb begin
      digit = 4'd0;
      valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (seg == digit_glyph(4'(i))) begin
            digit = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light controller pins: locks onto the phase
// sequence, checks phase lengths and the countdown display, latches the first error.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int RED_CYC    = 10,
   parameter int RY_CYC     = 4,
   parameter int GREEN_CYC  = 10,
   parameter int GBLINK_CYC = 6,
   parameter int YELLOW_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] lights_in,
   input  logic [6:0] seg_in,
   input  logic       err_clr,
   output logic [2:0] phase,
   output logic       locked,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic [7:0] cycles,
   output logic       err,
   output logic [2:0] err_code
);

   localparam logic [3:0] RED_L    = 4'(RED_CYC);
   localparam logic [3:0] RY_L     = 4'(RY_CYC);
   localparam logic [3:0] GREEN_L  = 4'(GREEN_CYC);
   localparam logic [3:0] GBLINK_L = 4'(GBLINK_CYC);
   localparam logic [3:0] YELLOW_L = 4'(YELLOW_CYC);

   phase_e     phase_q, phase_d;
   logic [3:0] n_q, n_d;
   logic [7:0] cycles_q, cycles_d;
   logic       err_q, err_d;
   logic [2:0] err_code_q, err_code_d;
   logic [3:0] digit_q;
   logic       digit_valid_q;

   logic [3:0] dec_digit;
   logic       dec_valid;

   pat_e       stay_pat, exit_pat;
   phase_e     next_ph;
   logic [3:0] lim, n_inc, exp_digit;
   logic       pat_legal, is_stay, is_exit, at_lim;
   err_e       err_new;
   logic       any_err;

   seg7_decoder u_dec (
      .seg   (seg_in),
      .digit (dec_digit),
      .valid (dec_valid)
   );

   // Per-phase expectations: the pattern that extends the phase, the one that ends it
   always_comb begin
      stay_pat = PAT_R;
      exit_pat = PAT_RY;
      lim      = RED_L;
      next_ph  = PH_RED_YELLOW;
      n_inc    = n_q + 4'd1;
      case (phase_q)
         PH_RED_YELLOW: begin
            stay_pat = PAT_RY;  exit_pat = PAT_G;   lim = RY_L;     next_ph = PH_GREEN;
         end
         PH_GREEN: begin
            stay_pat = PAT_G;   exit_pat = PAT_OFF; lim = GREEN_L;  next_ph = PH_GREEN_BLINK;
         end
         PH_GREEN_BLINK: begin
            stay_pat = n_inc[0] ? PAT_OFF : PAT_G;
            exit_pat = PAT_Y;   lim = GBLINK_L;     next_ph = PH_YELLOW;
         end
         PH_YELLOW: begin
            stay_pat = PAT_Y;   exit_pat = PAT_R;   lim = YELLOW_L; next_ph = PH_RED;
         end
         default: ;
      endcase

      pat_legal = lights_in inside {PAT_OFF, PAT_R, PAT_Y, PAT_RY, PAT_G};
      is_stay   = (lights_in == stay_pat);
      is_exit   = (lights_in == exit_pat);
      at_lim    = (n_q == lim);

      // Red counts down to 0 against the run count this sample produces
      exp_digit = 4'd0;
      if (lights_in == PAT_R)
         exp_digit = (phase_q == PH_RED) ? RED_L - n_inc : RED_L - 4'd1;

      err_new = ERR_NONE;
      if (!pat_legal)                        err_new = ERR_ILLEGAL;
      else if (is_exit && !at_lim)           err_new = ERR_EARLY;
      else if (is_stay && at_lim)            err_new = ERR_LATE;
      else if (!is_stay && !is_exit)         err_new = ERR_WRONG_NEXT;
      else if (dec_digit != exp_digit)       err_new = ERR_SEG_MISMATCH;
      else if (!dec_valid)                   err_new = ERR_SEG_INVALID;
      any_err = (phase_q != PH_SYNC) && (err_new != ERR_NONE);
   end

   always_comb begin
      phase_d    = phase_q;
      n_d        = n_q;
      cycles_d   = cycles_q;
      err_d      = err_q;
      err_code_d = err_code_q;

      if (phase_q == PH_SYNC) begin
         if (lights_in == PAT_R && dec_valid && dec_digit == RED_L - 4'd1) begin
            phase_d = PH_RED;
            n_d     = 4'd1;
         end
      end else if (any_err) begin
         phase_d = PH_SYNC;
         n_d     = 4'd0;
      end else if (is_stay) begin
         n_d = n_inc;
      end else begin
         phase_d = next_ph;
         n_d     = 4'd1;
         if (phase_q == PH_YELLOW)
            cycles_d = cycles_q + 8'd1;
      end

      if (err_clr) begin
         err_d      = 1'b0;
         err_code_d = 3'd0;
      end
      // A fresh error beats a same-cycle clear; otherwise the first code sticks
      if (any_err) begin
         err_d = 1'b1;
         if (!err_q || err_clr)
            err_code_d = err_new;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q       <= PH_SYNC;
         n_q           <= 4'd0;
         cycles_q      <= 8'd0;
         err_q         <= 1'b0;
         err_code_q    <= 3'd0;
         digit_q       <= 4'd0;
         digit_valid_q <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         n_q           <= n_d;
         cycles_q      <= cycles_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         digit_q       <= dec_digit;
         digit_valid_q <= dec_valid;
      end
   end

   assign phase       = phase_q;
   assign locked      = (phase_q != PH_SYNC);
   assign digit       = digit_q;
   assign digit_valid = digit_valid_q;
   assign cycles      = cycles_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: golden sequence, each error code,
// sticky/clear behaviour, and cycle-counter wrap with all phase lengths at 1.
module tb_traffic_light_monitor;

   localparam logic [2:0] L_OFF = 3'b000;
   localparam logic [2:0] L_R   = 3'b001;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_RY  = 3'b011;
   localparam logic [2:0] L_G   = 3'b100;
   localparam logic [6:0] BLANK = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] lights = 3'b000;
   logic [6:0] seg = 7'b0000000;
   logic       err_clr = 1'b0;

   logic [2:0] phase, phase1;
   logic       locked, locked1;
   logic [3:0] digit, digit1;
   logic       digit_valid, digit_valid1;
   logic [7:0] cycles, cycles1;
   logic       err, err1;
   logic [2:0] err_code, err_code1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   traffic_light_monitor dut (
      .clk(clk), .rst_n(rst_n), .lights_in(lights), .seg_in(seg), .err_clr(err_clr),
      .phase(phase), .locked(locked), .digit(digit), .digit_valid(digit_valid),
      .cycles(cycles), .err(err), .err_code(err_code)
   );

   traffic_light_monitor #(
      .RED_CYC(1), .RY_CYC(1), .GREEN_CYC(1), .GBLINK_CYC(1), .YELLOW_CYC(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .lights_in(lights), .seg_in(seg), .err_clr(err_clr),
      .phase(phase1), .locked(locked1), .digit(digit1), .digit_valid(digit_valid1),
      .cycles(cycles1), .err(err1), .err_code(err_code1)
   );

   function automatic logic [6:0] gl(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // One sample per call; outputs are read 1 time unit after the edge
   task automatic drv_seg(input logic [2:0] l, input logic [6:0] s);
      lights = l;
      seg    = s;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [2:0] l, input int d);
      drv_seg(l, gl(d));
   endtask

   task automatic play(input logic [2:0] l, input int cnt);
      for (int i = 0; i < cnt; i++) drv(l, 0);
   endtask

   task automatic red_down(input int first, input int last);
      for (int d = first; d >= last; d--) drv(L_R, d);
   endtask

   task automatic do_reset();
      err_clr = 1'b0;
      rst_n   = 1'b0;
      drv(L_OFF, 0);
      drv(L_OFF, 0);
      rst_n   = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drv(L_R, 9);
      drv(L_R, 9);
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
      total++; if (digit !== 4'd0) begin bad++; $display("FAIL reset_digit got=%0d want=0", digit); end
      total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL reset_dvalid got=%0b want=0", digit_valid); end
      total++; if (cycles !== 8'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
      total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", err_code); end
      rst_n = 1'b1;
   endtask

   task automatic test_golden();
      do_reset();
      for (int i = 0; i < 7; i++) drv_seg((i % 2 == 0) ? L_Y : L_OFF, BLANK);
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL golden_idle_phase got=%0d want=0", phase); end
      for (int d = 9; d >= 0; d--) begin
         drv(L_R, d);
         total++; if (phase !== 3'd1 || digit !== 4'(d) || digit_valid !== 1'b1)
            begin bad++; $display("FAIL golden_red phase=%0d digit=%0d want phase=1 digit=%0d", phase, digit, d); end
      end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL golden_locked got=%0b want=1", locked); end
      for (int i = 0; i < 4; i++) begin
         drv(L_RY, 0);
         total++; if (phase !== 3'd2) begin bad++; $display("FAIL golden_ry got=%0d want=2", phase); end
      end
      for (int i = 0; i < 10; i++) begin
         drv(L_G, 0);
         total++; if (phase !== 3'd3) begin bad++; $display("FAIL golden_green got=%0d want=3", phase); end
      end
      for (int i = 0; i < 6; i++) begin
         drv((i % 2 == 0) ? L_OFF : L_G, 0);
         total++; if (phase !== 3'd4) begin bad++; $display("FAIL golden_blink got=%0d want=4", phase); end
      end
      for (int i = 0; i < 4; i++) begin
         drv(L_Y, 0);
         total++; if (phase !== 3'd5) begin bad++; $display("FAIL golden_yellow got=%0d want=5", phase); end
      end
      total++; if (cycles !== 8'd0) begin bad++; $display("FAIL golden_cycles_pre got=%0d want=0", cycles); end
      drv(L_R, 9);
      total++; if (phase !== 3'd1) begin bad++; $display("FAIL golden_rered got=%0d want=1", phase); end
      total++; if (cycles !== 8'd1) begin bad++; $display("FAIL golden_cycles got=%0d want=1", cycles); end
      total++; if (err !== 1'b0 || err_code !== 3'd0)
         begin bad++; $display("FAIL golden_err err=%0b code=%0d want 0/0", err, err_code); end
   endtask

   task automatic test_early_late();
      do_reset();
      red_down(9, 1);
      drv(L_RY, 0);
      total++; if (err_code !== 3'd2 || phase !== 3'd0 || err !== 1'b1)
         begin bad++; $display("FAIL early code=%0d phase=%0d err=%0b want 2/0/1", err_code, phase, err); end
      do_reset();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_clears_err got=%0b want=0", err); end
      red_down(9, 0);
      play(L_RY, 4);
      play(L_G, 10);
      total++; if (phase !== 3'd3 || err !== 1'b0)
         begin bad++; $display("FAIL late_pre phase=%0d err=%0b want 3/0", phase, err); end
      drv(L_G, 0);
      total++; if (err_code !== 3'd3 || phase !== 3'd0)
         begin bad++; $display("FAIL late code=%0d phase=%0d want 3/0", err_code, phase); end
   endtask

   task automatic test_illegal_wrong();
      do_reset();
      red_down(9, 0);
      play(L_RY, 4);
      play(L_G, 5);
      drv(3'b111, 0);
      total++; if (err_code !== 3'd1) begin bad++; $display("FAIL illegal code=%0d want=1", err_code); end
      do_reset();
      red_down(9, 0);
      play(L_RY, 4);
      play(L_G, 10);
      drv(L_OFF, 0);
      drv(L_G, 0);
      drv(L_G, 0);
      total++; if (err_code !== 3'd4 || phase !== 3'd0)
         begin bad++; $display("FAIL wrong_next code=%0d phase=%0d want 4/0", err_code, phase); end
   endtask

   task automatic test_display();
      do_reset();
      red_down(9, 7);
      drv(L_R, 5);
      total++; if (err_code !== 3'd5) begin bad++; $display("FAIL seg_mismatch code=%0d want=5", err_code); end
      do_reset();
      red_down(9, 1);
      drv_seg(L_R, BLANK);
      total++; if (err_code !== 3'd6) begin bad++; $display("FAIL seg_invalid code=%0d want=6", err_code); end
      do_reset();
      drv(L_R, 9);
      drv_seg(L_R, BLANK);
      total++; if (err_code !== 3'd5) begin bad++; $display("FAIL seg_both code=%0d want=5", err_code); end
   endtask

   task automatic test_sticky_clear();
      do_reset();
      red_down(9, 1);
      drv(L_RY, 0);
      red_down(9, 0);
      total++; if (phase !== 3'd1) begin bad++; $display("FAIL relock phase=%0d want=1", phase); end
      drv(L_R, 0);
      total++; if (err_code !== 3'd2 || err !== 1'b1 || phase !== 3'd0)
         begin bad++; $display("FAIL sticky code=%0d err=%0b phase=%0d want 2/1/0", err_code, err, phase); end
      err_clr = 1'b1;
      drv(L_OFF, 0);
      err_clr = 1'b0;
      total++; if (err !== 1'b0 || err_code !== 3'd0)
         begin bad++; $display("FAIL clear err=%0b code=%0d want 0/0", err, err_code); end
      drv(L_R, 9);
      drv(L_R, 0);
      total++; if (err_code !== 3'd5) begin bad++; $display("FAIL pre_clr_err code=%0d want=5", err_code); end
      drv(L_R, 9);
      err_clr = 1'b1;
      drv(L_RY, 0);
      err_clr = 1'b0;
      total++; if (err !== 1'b1 || err_code !== 3'd2)
         begin bad++; $display("FAIL clr_with_err err=%0b code=%0d want 1/2", err, err_code); end
   endtask

   task automatic test_wrap();
      do_reset();
      drv(L_R, 0);
      total++; if (phase1 !== 3'd1) begin bad++; $display("FAIL wrap_lock phase=%0d want=1", phase1); end
      for (int c = 1; c <= 256; c++) begin
         drv(L_RY, 0);
         drv(L_G, 0);
         drv(L_OFF, 0);
         drv(L_Y, 0);
         drv(L_R, 0);
         if (c == 1 || c == 255) begin
            total++; if (cycles1 !== 8'(c)) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", cycles1, c); end
         end
      end
      total++; if (cycles1 !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", cycles1); end
      total++; if (err1 !== 1'b0 || phase1 !== 3'd1)
         begin bad++; $display("FAIL wrap_state err=%0b phase=%0d want 0/1", err1, phase1); end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_early_late();
      test_illegal_wrong();
      test_display();
      test_sticky_clear();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
